// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI mode 3 slave (CPOL=1, CPHA=1), MSB first, fixed DATA_WIDTH-bit frames.
// All logic runs on the internal clock. sclk, cs_bar and mosi are asynchronous
// pins that are synchronized and edge-detected before use.
//
// Ports
//   clk          internal clock, rising edge
//   reset        synchronous, active-high reset
//   sclk         SPI clock from master (idle high)
//   cs_bar       chip select, active low
//   mosi         serial data from master
//   miso         serial data to master (0 whenever no frame is shifting)
//   tx_data      word for the next frame
//   tx_load      write strobe for tx_data, honoured only while tx_ready=1
//   tx_ready     holding register empty
//   rx_data      last complete received word
//   rx_valid     one-cycle pulse, rx_data updated
//   frame_err    one-cycle pulse, short frame or extra sclk edges
//   tx_underrun  one-cycle pulse, frame started with empty holding register
//   busy         high while a frame is shifting or awaiting deselect
// -----------------------------------------------------------------------------
module spi_slave_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  cs_bar,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_load,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  tx_underrun,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int SET_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DATA_WIDTH);
   localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      WAIT_DESEL,
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // ---------------------------------------------------------------- state
   state_t                  state_q,      state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q,  sclk_sync_d;
   logic [SYNC_STAGES-1:0]  cs_sync_q,    cs_sync_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q,  mosi_sync_d;
   logic                    sclk_dly_q,   sclk_dly_d;
   logic                    cs_dly_q,     cs_dly_d;
   logic [DATA_WIDTH-1:0]   hold_q,       hold_d;
   logic                    hold_full_q,  hold_full_d;
   logic [DATA_WIDTH-1:0]   shift_reg_q,  shift_reg_d;
   logic [DATA_WIDTH-1:0]   rx_shift_q,   rx_shift_d;
   logic [CNT_W-1:0]        rx_cnt_q,     rx_cnt_d;
   logic [SET_W-1:0]        settle_q,     settle_d;
   logic                    err_seen_q,   err_seen_d;
   logic                    miso_q,       miso_d;
   logic [DATA_WIDTH-1:0]   rx_data_q,    rx_data_d;
   logic                    rx_valid_q,   rx_valid_d;
   logic                    frame_err_q,  frame_err_d;
   logic                    tx_underrun_q, tx_underrun_d;
   logic                    busy_q,       busy_d;

   // Synchronized pin values and detected edges
   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s &  sclk_dly_q;
   assign cs_rise   =  cs_s   & ~cs_dly_q;
   assign cs_fall   = ~cs_s   &  cs_dly_q;

   assign miso        = miso_q;
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign tx_underrun = tx_underrun_q;
   assign busy        = busy_q;

   // ---------------------------------------------------------- next state
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      shift_reg_d   = shift_reg_q;
      rx_shift_d    = rx_shift_q;
      rx_cnt_d      = rx_cnt_q;
      settle_d      = settle_q;
      err_seen_d    = err_seen_q;
      miso_d        = miso_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      frame_err_d   = 1'b0;
      tx_underrun_d = 1'b0;

      // Synchronizer chains shift towards the MSB; the MSB is the usable value.
      sclk_sync_d    = sclk_sync_q << 1;
      sclk_sync_d[0] = sclk;
      cs_sync_d      = cs_sync_q << 1;
      cs_sync_d[0]   = cs_bar;
      mosi_sync_d    = mosi_sync_q << 1;
      mosi_sync_d[0] = mosi;
      sclk_dly_d     = sclk_s;
      cs_dly_d       = cs_s;

      case (state_q)
         WAIT_DESEL: begin
            miso_d = 1'b0;
            // The synchronizers come out of reset preset to "deselected", so
            // they must first flush real pin values before cs_bar=1 can be
            // trusted; otherwise a frame in flight at reset release would be
            // joined part-way through.
            if (settle_q != SETTLE_DONE) begin
               settle_d = settle_q + SET_W'(1);
            end else if (cs_s) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d       = SHIFT;
               shift_reg_d   = hold_full_q ? hold_q : '0;
               miso_d        = hold_full_q & hold_q[DATA_WIDTH-1];
               tx_underrun_d = ~hold_full_q;
               hold_full_d   = 1'b0;
               rx_cnt_d      = '0;
               rx_shift_d    = '0;
            end
         end

         SHIFT: begin
            if (rx_cnt_q == FULL_CNT) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               state_d    = DONE;
               miso_d     = 1'b0;
               err_seen_d = 1'b0;
            end else if (cs_rise) begin
               // Master deselected before a full word: drop it.
               frame_err_d = 1'b1;
               state_d     = IDLE;
               miso_d      = 1'b0;
            end else begin
               // Falling edge k presents original bit DATA_WIDTH-k: the first
               // fall repeats the MSB already driven at frame start, then the
               // register shifts left so the next bit is always at the top.
               if (sclk_fall) begin
                  miso_d      = shift_reg_q[DATA_WIDTH-1];
                  shift_reg_d = shift_reg_q << 1;
               end
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                  rx_cnt_d   = rx_cnt_q + CNT_W'(1);
               end
            end
         end

         DONE: begin
            miso_d = 1'b0;
            // Extra clocks are discarded; report them only once per frame.
            if (sclk_rise && !err_seen_q) begin
               frame_err_d = 1'b1;
               err_seen_d  = 1'b1;
            end
            if (cs_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = WAIT_DESEL;
            miso_d  = 1'b0;
         end
      endcase

      // Applied after frame-start consumption, so a load accepted in the
      // start cycle waits in the holding register for the following frame.
      if (tx_load && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      busy_d = (state_d == SHIFT) || (state_d == DONE);
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WAIT_DESEL;
         sclk_sync_q   <= '1;
         cs_sync_q     <= '1;
         mosi_sync_q   <= '0;
         sclk_dly_q    <= 1'b1;
         cs_dly_q      <= 1'b1;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         shift_reg_q   <= '0;
         rx_shift_q    <= '0;
         rx_cnt_q      <= '0;
         settle_q      <= '0;
         err_seen_q    <= 1'b0;
         miso_q        <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         tx_underrun_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         cs_sync_q     <= cs_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sclk_dly_q    <= sclk_dly_d;
         cs_dly_q      <= cs_dly_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         shift_reg_q   <= shift_reg_d;
         rx_shift_q    <= rx_shift_d;
         rx_cnt_q      <= rx_cnt_d;
         settle_q      <= settle_d;
         err_seen_q    <= err_seen_d;
         miso_q        <= miso_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         tx_underrun_q <= tx_underrun_d;
         busy_q        <= busy_d;
      end
   end

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Directed bench for spi_slave_responder at default parameters. A bus-master
// task drives mode-3 frames at sclk = clk/8 and collects miso bits just before
// each rising sclk edge; a monitor counts output pulses so each scenario can
// check how many rx_valid / frame_err / tx_underrun pulses it produced.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        sclk;
   logic        cs_bar;
   logic        mosi;
   logic        miso;
   logic [15:0] tx_data;
   logic        tx_load;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        tx_underrun;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_rxv    = 0;
   int n_ferr   = 0;
   int n_und    = 0;

   always #5 clk = ~clk;

   spi_slave_responder dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .cs_bar      (cs_bar),
      .mosi        (mosi),
      .miso        (miso),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
      .tx_underrun (tx_underrun),
      .busy        (busy)
   );

   always @(negedge clk) begin
      if (rx_valid)    n_rxv++;
      if (frame_err)   n_ferr++;
      if (tx_underrun) n_und++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [15:0] w);
      tx_data = w;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   // Sends nbits clocks; bits past 16 carry mosi=1. A one-cycle reset pulse is
   // inserted at the start of bit rst_bit (pass -1 for none).
   task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_bit,
                            output logic [31:0] mbits);
      mbits  = '0;
      cs_bar = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         sclk = 1'b0;
         mosi = (i < 16) ? word[15-i] : 1'b1;
         repeat (HALF) @(negedge clk);
         mbits = {mbits[30:0], miso};
         sclk  = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      cs_bar = 1'b1;
      mosi   = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      logic [31:0] mb;
      int v0, e0, u0;

      reset   = 1'b1;
      sclk    = 1'b1;
      cs_bar  = 1'b1;
      mosi    = 1'b0;
      tx_data = '0;
      tx_load = 1'b0;
      repeat (4) @(negedge clk);

      check("rst_miso",      {31'd0, miso},        32'd0);
      check("rst_rx_data",   {16'd0, rx_data},     32'd0);
      check("rst_rx_valid",  {31'd0, rx_valid},    32'd0);
      check("rst_frame_err", {31'd0, frame_err},   32'd0);
      check("rst_underrun",  {31'd0, tx_underrun}, 32'd0);
      check("rst_busy",      {31'd0, busy},        32'd0);
      check("rst_tx_ready",  {31'd0, tx_ready},    32'd1);

      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Basic frame: transmit 0xA5C3 while receiving 0x1234.
      load_word(16'hA5C3);
      check("load_tx_ready", {31'd0, tx_ready}, 32'd0);
      v0 = n_rxv; e0 = n_ferr; u0 = n_und;
      spi_frame(16'h1234, 16, -1, mb);
      check("f1_miso",      mb & 32'hFFFF,       32'h0000A5C3);
      check("f1_rx_data",   {16'd0, rx_data},    32'h00001234);
      check("f1_rx_valid",  n_rxv - v0,          32'd1);
      check("f1_frame_err", n_ferr - e0,         32'd0);
      check("f1_underrun",  n_und - u0,          32'd0);
      check("f1_tx_ready",  {31'd0, tx_ready},   32'd1);
      check("f1_idle_miso", {31'd0, miso},       32'd0);
      check("f1_idle_busy", {31'd0, busy},       32'd0);

      // Underrun: nothing loaded.
      v0 = n_rxv; u0 = n_und;
      spi_frame(16'h0F0F, 16, -1, mb);
      check("ur_underrun", n_und - u0,          32'd1);
      check("ur_miso",     mb & 32'hFFFF,       32'd0);
      check("ur_rx_data",  {16'd0, rx_data},    32'h00000F0F);
      check("ur_rx_valid", n_rxv - v0,          32'd1);

      // Short frame of 9 clocks, then a good frame.
      v0 = n_rxv; e0 = n_ferr;
      spi_frame(16'hFFFF, 9, -1, mb);
      check("sh_frame_err", n_ferr - e0,        32'd1);
      check("sh_rx_valid",  n_rxv - v0,         32'd0);
      check("sh_rx_data",   {16'd0, rx_data},   32'h00000F0F);
      load_word(16'h1357);
      v0 = n_rxv; e0 = n_ferr;
      spi_frame(16'hBEEF, 16, -1, mb);
      check("sh2_rx_data",   {16'd0, rx_data},  32'h0000BEEF);
      check("sh2_rx_valid",  n_rxv - v0,        32'd1);
      check("sh2_frame_err", n_ferr - e0,       32'd0);
      check("sh2_miso",      mb & 32'hFFFF,     32'h00001357);

      // Long frame of 20 clocks: word captured, one error for the extras.
      load_word(16'h8001);
      v0 = n_rxv; e0 = n_ferr;
      spi_frame(16'hCAFE, 20, -1, mb);
      check("lg_rx_data",   {16'd0, rx_data},   32'h0000CAFE);
      check("lg_rx_valid",  n_rxv - v0,         32'd1);
      check("lg_frame_err", n_ferr - e0,        32'd1);
      check("lg_miso",      mb & 32'hFFFFF,     32'h00080010);

      // Reset at bit 8 with chip select held through 16 clocks.
      v0 = n_rxv;
      spi_frame(16'hAAAA, 16, 8, mb);
      check("rm_rx_valid", n_rxv - v0,          32'd0);
      check("rm_rx_data",  {16'd0, rx_data},    32'd0);
      v0 = n_rxv;
      spi_frame(16'h00FF, 16, -1, mb);
      check("rm2_rx_data",  {16'd0, rx_data},   32'h000000FF);
      check("rm2_rx_valid", n_rxv - v0,         32'd1);

      // Second load while not ready is dropped.
      load_word(16'h1111);
      check("dl_tx_ready", {31'd0, tx_ready},   32'd0);
      load_word(16'h5555);
      u0 = n_und;
      spi_frame(16'h2468, 16, -1, mb);
      check("dl_miso",     mb & 32'hFFFF,       32'h00001111);
      check("dl_underrun", n_und - u0,          32'd0);
      check("dl_rx_data",  {16'd0, rx_data},    32'h00002468);
      u0 = n_und;
      spi_frame(16'h0000, 16, -1, mb);
      check("dl2_underrun", n_und - u0,         32'd1);
      check("dl2_miso",     mb & 32'hFFFF,      32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
